base_fifo_sync: RTL

BASE_FIFO_SYNC -- requirements
Module: base_fifo_sync

---
 rtl/base_fifo_sync.sv | 135 +++++++++++++
 1 files changed

// File: rtl/base_fifo_sync.sv
// Synchronous FIFO, Depth words, standard or first-word-fall-through read; flags registered from next count.
// Define BASE_FIFO_SYNC_ERRFLAG_EN to add sticky Overflow/Underflow outputs.
module base_fifo_sync #(
  parameter int Width          = 8,
  parameter int Depth          = 12,
  parameter int FirstWordFall  = 0,
  parameter int ProgFullValue  = 9,
  parameter int ProgEmptyValue = 2,
  parameter int DataCountWidth = $clog2(Depth + 1)
) (
  input  logic                      Clk,
  input  logic                      ResetN,
  input  logic                      Write,
  input  logic [Width-1:0]          Din,
  input  logic                      Read,
  output logic [Width-1:0]          Dout,
  output logic                      Valid,
  output logic                      Full,
  output logic                      Empty,
  output logic                      ProgFull,
  output logic                      ProgEmpty,
  output logic [DataCountWidth-1:0] DataCount
`ifdef BASE_FIFO_SYNC_ERRFLAG_EN
  ,
  output logic                      Overflow,
  output logic                      Underflow
`endif
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] LastPtr = AW'(Depth - 1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [DataCountWidth-1:0] CntOne   = DataCountWidth'(1);
  localparam logic [DataCountWidth-1:0] CntDepth = DataCountWidth'(Depth);
  localparam logic [DataCountWidth-1:0] CntPf    = DataCountWidth'(ProgFullValue);
  localparam logic [DataCountWidth-1:0] CntPe    = DataCountWidth'(ProgEmptyValue);

  if (Depth < 2 || Depth > 4096) begin : g_bad_depth
    $error("base_fifo_sync: Depth must be within 2..4096");
  end
  if (!(ProgEmptyValue < ProgFullValue && ProgFullValue <= Depth)) begin : g_bad_prog
    $error("base_fifo_sync: need ProgEmptyValue < ProgFullValue <= Depth");
  end

  logic [Width-1:0]          mem_q [Depth];
  logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DataCountWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0]          dout_q, dout_d;
  logic                      valid_q, valid_d;
  logic                      full_q, empty_q, empty_d, pfull_q, pempty_q;
  logic                      wr_en, pop, mem_rd;

  always_comb begin
    wr_en = Write & ~full_q;
    if (FirstWordFall != 0) begin
      // Count includes the output register, so memory holds words iff count exceeds valid.
      pop     = Read & valid_q;
      mem_rd  = (cnt_q != DataCountWidth'(valid_q)) & (~valid_q | pop);
      valid_d = mem_rd | (valid_q & ~pop);
    end else begin
      pop     = Read & ~empty_q;
      mem_rd  = pop;
      valid_d = pop;
    end

    dout_d = mem_rd ? mem_q[rptr_q] : dout_q;

    wptr_d = wptr_q;
    if (wr_en) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrOne;
    rptr_d = rptr_q;
    if (mem_rd) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrOne;

    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CntOne;
    else if (!wr_en && pop) cnt_d = cnt_q - CntOne;

    empty_d = (FirstWordFall != 0) ? ~valid_d : (cnt_d == '0);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wptr_q] <= Din;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      full_q   <= (cnt_d == CntDepth);
      empty_q  <= empty_d;
      pfull_q  <= (cnt_d >= CntPf);
      pempty_q <= (cnt_d <= CntPe);
    end
  end

`ifdef BASE_FIFO_SYNC_ERRFLAG_EN
  logic ovf_q, unf_q;

  // In FWFT mode empty_q tracks ~valid_q, so one term covers both read styles.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (Write & full_q) ovf_q <= 1'b1;
      if (Read & empty_q) unf_q <= 1'b1;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`endif

  assign Dout      = dout_q;
  assign Valid     = valid_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign ProgFull  = pfull_q;
  assign ProgEmpty = pempty_q;
  assign DataCount = cnt_q;

endmodule
